// File: rtl/guess_game_pkg.sv
// Shared types and helpers for the guess game scorer: FSM state encoding,
// output width helpers and digit extraction from a packed code word.
package guess_game_pkg;

    typedef enum logic [2:0] {
        IDLE,
        READY,
        EXACT,
        WRONG,
        REPORT,
        WON,
        LOST
    } state_t;

    // Widest packed code and widest digit the digit() helper can handle.
    localparam int MAX_CODE_W  = 64;
    localparam int MAX_DIGIT_W = 16;

    // Width of a count that must hold 0..num_digits.
    function automatic int cnt_width(input int num_digits);
        return $clog2(num_digits + 1);
    endfunction

    // Width of a count that must hold 0..max_tries.
    function automatic int try_width(input int max_tries);
        return $clog2(max_tries + 1);
    endfunction

    // Digit i of a packed code; digit 0 occupies the most significant bits.
    function automatic logic [MAX_DIGIT_W-1:0] digit(
        input logic [MAX_CODE_W-1:0] code,
        input int                    num_digits,
        input int                    digit_w,
        input int                    i
    );
        logic [MAX_CODE_W-1:0] mask;
        logic [MAX_CODE_W-1:0] shifted;
        mask    = (MAX_CODE_W'(1) << digit_w) - MAX_CODE_W'(1);
        shifted = code >> ((num_digits - 1 - i) * digit_w);
        return MAX_DIGIT_W'(shifted & mask);
    endfunction

endpackage

// File: rtl/guess_match_unit.sv
// Sequential scoring datapath. Holds the secret and the current guess,
// marks exact-position matches in one step, then walks the guess one digit
// per step pairing each non-exact digit with the lowest unused secret digit
// of the same value, so duplicates are never counted twice.
module guess_match_unit
    import guess_game_pkg::*;
#(
    parameter  int NUM_DIGITS = 4,
    parameter  int DIGIT_W    = 4,
    localparam int CODE_W     = NUM_DIGITS * DIGIT_W,
    localparam int CNT_W      = cnt_width(NUM_DIGITS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              secret_load,
    input  logic [CODE_W-1:0] secret_in,
    input  logic              start,
    input  logic [CODE_W-1:0] guess_in,
    input  logic              exact_step,
    input  logic              wrong_step,
    output logic              done,
    output logic [CNT_W-1:0]  correct_digits,
    output logic [CNT_W-1:0]  wrong_place_digits
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [CODE_W-1:0]     secret_q;
    logic [CODE_W-1:0]     guess_q;
    logic [NUM_DIGITS-1:0] exact_q;
    logic [NUM_DIGITS-1:0] used_q;
    logic [IDX_W-1:0]      idx_q;
    logic [CNT_W-1:0]      correct_q;
    logic [CNT_W-1:0]      wrong_q;

    logic [DIGIT_W-1:0]    s_dig [NUM_DIGITS];
    logic [DIGIT_W-1:0]    g_dig [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] exact_now;
    logic [CNT_W-1:0]      exact_cnt;
    logic                  found;
    logic [IDX_W-1:0]      k_sel;

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digits
        assign s_dig[gi] = DIGIT_W'(digit(MAX_CODE_W'(secret_q), NUM_DIGITS, DIGIT_W, gi));
        assign g_dig[gi] = DIGIT_W'(digit(MAX_CODE_W'(guess_q), NUM_DIGITS, DIGIT_W, gi));
    end

    // Exact-position mask and its population count.
    always_comb begin
        exact_now = '0;
        exact_cnt = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            exact_now[i] = (s_dig[i] == g_dig[i]);
            exact_cnt    = exact_cnt + CNT_W'(exact_now[i]);
        end
    end

    // Lowest unused secret position whose value equals guess digit idx_q;
    // scanning downward lets the lowest hit overwrite higher ones.
    always_comb begin
        found = 1'b0;
        k_sel = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            if (!used_q[k] && (s_dig[k] == g_dig[idx_q])) begin
                found = 1'b1;
                k_sel = IDX_W'(k);
            end
        end
    end

    assign done               = wrong_step && (idx_q == IDX_W'(NUM_DIGITS - 1));
    assign correct_digits     = correct_q;
    assign wrong_place_digits = wrong_q;

    // Secret/guess capture and the exact/wrong scoring steps.
    always_ff @(posedge clk) begin
        if (rst) begin
            secret_q  <= '0;
            guess_q   <= '0;
            exact_q   <= '0;
            used_q    <= '0;
            idx_q     <= '0;
            correct_q <= '0;
            wrong_q   <= '0;
        end else if (secret_load) begin
            secret_q  <= secret_in;
            exact_q   <= '0;
            used_q    <= '0;
            idx_q     <= '0;
            correct_q <= '0;
            wrong_q   <= '0;
        end else if (start) begin
            guess_q   <= guess_in;
            idx_q     <= '0;
            correct_q <= '0;
            wrong_q   <= '0;
        end else if (exact_step) begin
            exact_q   <= exact_now;
            used_q    <= exact_now;
            correct_q <= exact_cnt;
            idx_q     <= '0;
        end else if (wrong_step) begin
            if (!exact_q[idx_q] && found) begin
                used_q[k_sel] <= 1'b1;
                wrong_q       <= wrong_q + CNT_W'(1);
            end
            idx_q <= done ? '0 : idx_q + IDX_W'(1);
        end
    end

endmodule

// File: rtl/guess_game_scorer.sv
// Clocked guess game scorer: holds the secret, accepts guesses, scores them
// through guess_match_unit, counts attempts and flags win/loss.
//
// Guess handshake: a guess transfers on a rising edge where guess_valid and
// guess_ready are both high and secret_load is low. guess_ready is high only
// in READY and does not depend on guess_valid; a guess offered while
// guess_ready is low is dropped, not queued. score_valid is a one-cycle pulse
// with no back-pressure.
module guess_game_scorer
    import guess_game_pkg::*;
#(
    parameter  int NUM_DIGITS = 4,
    parameter  int DIGIT_W    = 4,
    parameter  int MAX_TRIES  = 8,
    localparam int CODE_W     = NUM_DIGITS * DIGIT_W,
    localparam int CNT_W      = cnt_width(NUM_DIGITS),
    localparam int TRY_W      = try_width(MAX_TRIES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              secret_load,
    input  logic [CODE_W-1:0] secret_in,
    input  logic              guess_valid,
    input  logic [CODE_W-1:0] guess_in,
    output logic              guess_ready,
    output logic              score_valid,
    output logic [CNT_W-1:0]  correct_digits,
    output logic [CNT_W-1:0]  wrong_place_digits,
    output logic [TRY_W-1:0]  tries_used,
    output logic              game_won,
    output logic              game_lost
);

    state_t            state;
    state_t            state_next;
    logic              accept;
    logic              exact_step;
    logic              wrong_step;
    logic              match_done;
    logic              report_win;
    logic              report_loss;
    logic [TRY_W-1:0]  tries_q;
    logic              won_q;
    logic              lost_q;
    logic              score_valid_q;

    assign guess_ready = (state == READY);
    assign accept      = guess_valid && guess_ready && !secret_load;
    assign report_win  = (correct_digits == CNT_W'(NUM_DIGITS));
    assign report_loss = !report_win && (tries_q == TRY_W'(MAX_TRIES));

    guess_match_unit #(
        .NUM_DIGITS (NUM_DIGITS),
        .DIGIT_W    (DIGIT_W)
    ) u_match (
        .clk                (clk),
        .rst                (rst),
        .secret_load        (secret_load),
        .secret_in          (secret_in),
        .start              (accept),
        .guess_in           (guess_in),
        .exact_step         (exact_step),
        .wrong_step         (wrong_step),
        .done               (match_done),
        .correct_digits     (correct_digits),
        .wrong_place_digits (wrong_place_digits)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and datapath step strobes; secret_load overrides everything.
    always_comb begin
        state_next = state;
        exact_step = 1'b0;
        wrong_step = 1'b0;
        if (secret_load) begin
            state_next = READY;
        end else begin
            case (state)
                IDLE:   state_next = IDLE;
                READY:  if (accept) state_next = EXACT;
                EXACT: begin
                    exact_step = 1'b1;
                    state_next = WRONG;
                end
                WRONG: begin
                    wrong_step = 1'b1;
                    if (match_done) state_next = REPORT;
                end
                REPORT: begin
                    if (report_win) begin
                        state_next = WON;
                    end else if (report_loss) begin
                        state_next = LOST;
                    end else begin
                        state_next = READY;
                    end
                end
                WON:     state_next = WON;
                LOST:    state_next = LOST;
                default: state_next = IDLE;
            endcase
        end
    end

    // Attempt counter: cleared by a new game, bumped on every accepted guess.
    always_ff @(posedge clk) begin
        if (rst || secret_load) begin
            tries_q <= '0;
        end else if (accept) begin
            tries_q <= tries_q + TRY_W'(1);
        end
    end

    // Outcome flags and the score pulse are committed on the edge leaving
    // REPORT, so score_valid, game_won/game_lost and the next state all
    // appear together in the same cycle.
    always_ff @(posedge clk) begin
        if (rst || secret_load) begin
            won_q         <= 1'b0;
            lost_q        <= 1'b0;
            score_valid_q <= 1'b0;
        end else begin
            score_valid_q <= (state == REPORT);
            if (state == REPORT) begin
                won_q  <= report_win;
                lost_q <= report_loss;
            end
        end
    end

    assign score_valid = score_valid_q;
    assign tries_used  = tries_q;
    assign game_won    = won_q;
    assign game_lost   = lost_q;

endmodule
